// File: rtl/txrx_pkg.sv
// rtl/txrx_pkg.sv - shared types and constants for the TX/RX link sequencer
//
// Holds the sequencer state encoding, the fixed load/capture durations, the
// completed-frame counter width and a helper that sizes the shared cycle
// counter so it can hold every preset the sequencer loads into it.
package txrx_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_TX_WR   = 4'd1,
        ST_TX_RD   = 4'd2,
        ST_LOAD    = 4'd3,
        ST_SHIFT   = 4'd4,
        ST_CAPTURE = 4'd5,
        ST_RX_WR   = 4'd6,
        ST_RX_RD   = 4'd7,
        ST_DONE    = 4'd8,
        ST_GAP     = 4'd9
    } state_e;

    localparam int LOAD_CYC    = 1;
    localparam int CAP_CYC     = 1;
    localparam int FRAME_CNT_W = 16;

    // Smallest width whose range covers WIDTH+1 (so WIDTH - count fits in
    // shift_cnt without overflow) and the largest gap preset GAP-1.
    function automatic int cnt_width(input int width, input int gap);
        int need;
        int w;
        need = (width + 1 > gap) ? width + 1 : gap;
        w = 1;
        while ((1 << w) <= need) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/txrx_cycle_counter.sv
// rtl/txrx_cycle_counter.sv - loadable down-counter with zero flag
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   load, load_val load a new count (has priority over dec)
//   dec            decrement by one; saturates at zero
//   count          current count
//   zero           count == 0
module txrx_cycle_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/txrx_link_ctrl.sv
// rtl/txrx_link_ctrl.sv - load/shift/capture sequencer for the byte-serial TX/RX loop
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_valid / req_ready    frame request handshake
//   abort                    synchronous cancel of the frame in flight
//   tx_wr, tx_rd             TX buffer write / read strobes
//   rx_wr, rx_rd             RX buffer write / read strobes
//   mode                     shifter mode: 1 = load/capture/hold, 0 = shift
//   shift_cnt                shift cycle index (0..WIDTH during SHIFT, else 0)
//   busy                     frame in flight or inter-frame gap running
//   done                     one-cycle pulse, RX buffer output holds the frame
//   aborted                  one-cycle pulse, frame cancelled
//   frame_cnt                completed frames, wraps
module txrx_link_ctrl
    import txrx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 0,
    parameter int CW    = $clog2(WIDTH + 2)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   abort,
    output logic                   tx_wr,
    output logic                   tx_rd,
    output logic                   rx_wr,
    output logic                   rx_rd,
    output logic                   mode,
    output logic [CW-1:0]          shift_cnt,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int CNT_W = cnt_width(WIDTH, GAP);

    // Presets are "cycles in state minus one": the counter reaches zero in
    // the final cycle of the state, which is when the FSM moves on.
    localparam logic [CNT_W-1:0] LOAD_PRESET  = CNT_W'(LOAD_CYC - 1);
    localparam logic [CNT_W-1:0] SHIFT_PRESET = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CAP_PRESET   = CNT_W'(CAP_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_PRESET   = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_e                 state_q;
    state_e                 state_d;
    logic                   aborted_q;
    logic                   aborted_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_d;

    logic                   cnt_load;
    logic [CNT_W-1:0]       cnt_load_val;
    logic                   cnt_dec;
    logic [CNT_W-1:0]       cnt_value;
    logic                   cnt_zero;

    txrx_cycle_counter #(
        .W(CNT_W)
    ) u_cycle_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt_value),
        .zero     (cnt_zero)
    );

    // rst gates req_ready directly so it is low for the whole reset window,
    // not only once the state register has been cleared.
    assign req_ready = (state_q == ST_IDLE) && !abort && rst;

    always_comb begin
        state_d      = state_q;
        aborted_d    = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        cnt_load     = 1'b0;
        cnt_load_val = SHIFT_PRESET;
        cnt_dec      = 1'b0;

        // DONE always lasts one cycle, so leaving it is counted here even
        // when abort arrives in that same cycle.
        if (state_q == ST_DONE) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end

        if (abort && (state_q != ST_IDLE)) begin
            state_d   = ST_IDLE;
            aborted_d = (state_q != ST_DONE);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        state_d = ST_TX_WR;
                    end
                end
                ST_TX_WR: begin
                    state_d = ST_TX_RD;
                end
                ST_TX_RD: begin
                    state_d      = ST_LOAD;
                    cnt_load     = 1'b1;
                    cnt_load_val = LOAD_PRESET;
                end
                ST_LOAD: begin
                    if (cnt_zero) begin
                        state_d      = ST_SHIFT;
                        cnt_load     = 1'b1;
                        cnt_load_val = SHIFT_PRESET;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    // WIDTH+1 cycles: the serialiser output register adds
                    // one cycle before the last bit reaches the deserialiser.
                    if (cnt_zero) begin
                        state_d      = ST_CAPTURE;
                        cnt_load     = 1'b1;
                        cnt_load_val = CAP_PRESET;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (cnt_zero) begin
                        state_d = ST_RX_WR;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                ST_RX_WR: begin
                    state_d = ST_RX_RD;
                end
                ST_RX_RD: begin
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (GAP > 0) begin
                        state_d      = ST_GAP;
                        cnt_load     = 1'b1;
                        cnt_load_val = GAP_PRESET;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (cnt_zero) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            aborted_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            aborted_q   <= aborted_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Moore decode from the state register only.
    always_comb begin
        tx_wr     = (state_q == ST_TX_WR);
        tx_rd     = (state_q == ST_TX_RD);
        rx_wr     = (state_q == ST_RX_WR);
        rx_rd     = (state_q == ST_RX_RD);
        mode      = (state_q != ST_SHIFT);
        done      = (state_q == ST_DONE);
        busy      = (state_q != ST_IDLE);
        shift_cnt = '0;
        if (state_q == ST_SHIFT) begin
            shift_cnt = CW'(SHIFT_PRESET - cnt_value);
        end
    end

    assign aborted   = aborted_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_txrx_link_ctrl.sv
// tb/tb_txrx_link_ctrl.sv - self-checking bench for txrx_link_ctrl
module tb_txrx_link_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        abort;
    logic        tx_wr;
    logic        tx_rd;
    logic        rx_wr;
    logic        rx_rd;
    logic        mode;
    logic [3:0]  shift_cnt;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] frame_cnt;

    logic        g_req_valid;
    logic        g_req_ready;
    logic        g_abort;
    logic        g_tx_wr;
    logic        g_tx_rd;
    logic        g_rx_wr;
    logic        g_rx_rd;
    logic        g_mode;
    logic [3:0]  g_shift_cnt;
    logic        g_busy;
    logic        g_done;
    logic        g_aborted;
    logic [15:0] g_frame_cnt;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    txrx_link_ctrl #(.WIDTH(8), .GAP(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .abort     (abort),
        .tx_wr     (tx_wr),
        .tx_rd     (tx_rd),
        .rx_wr     (rx_wr),
        .rx_rd     (rx_rd),
        .mode      (mode),
        .shift_cnt (shift_cnt),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .frame_cnt (frame_cnt)
    );

    txrx_link_ctrl #(.WIDTH(8), .GAP(3)) dut_g (
        .clk       (clk),
        .rst       (rst),
        .req_valid (g_req_valid),
        .req_ready (g_req_ready),
        .abort     (g_abort),
        .tx_wr     (g_tx_wr),
        .tx_rd     (g_tx_rd),
        .rx_wr     (g_rx_wr),
        .rx_rd     (g_rx_rd),
        .mode      (g_mode),
        .shift_cnt (g_shift_cnt),
        .busy      (g_busy),
        .done      (g_done),
        .aborted   (g_aborted),
        .frame_cnt (g_frame_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] vec;
    logic [31:0] g_vec;
    assign vec   = {3'b0, req_ready, tx_wr, tx_rd, rx_wr, rx_rd, mode, busy, done, aborted,
                    shift_cnt, frame_cnt};
    assign g_vec = {3'b0, g_req_ready, g_tx_wr, g_tx_rd, g_rx_wr, g_rx_rd, g_mode, g_busy,
                    g_done, g_aborted, g_shift_cnt, g_frame_cnt};

    function automatic logic [31:0] mk(input logic rr, input logic txw, input logic txr,
                                       input logic rxw, input logic rxr, input logic md,
                                       input logic bz, input logic dn, input logic ab,
                                       input logic [3:0] sc, input logic [15:0] fc);
        return {3'b0, rr, txw, txr, rxw, rxr, md, bz, dn, ab, sc, fc};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Buffer/shifter datapath driven only by the DUT strobes.
    logic [7:0] din;
    logic [7:0] tx_buf;
    logic [7:0] tx_out;
    logic [7:0] piso;
    logic       ser_q;
    logic [7:0] sipo;
    logic [7:0] rx_buf;
    logic [7:0] rx_out;

    always @(posedge clk) begin
        if (tx_wr) tx_buf <= din;
        if (tx_rd) tx_out <= tx_buf;
        if (mode) begin
            piso <= tx_out;
        end else begin
            piso  <= {piso[6:0], 1'b0};
            ser_q <= piso[7];
            sipo  <= {sipo[6:0], ser_q};
        end
        if (rx_wr) rx_buf <= sipo;
        if (rx_rd) rx_out <= rx_buf;
    end

    // Scoreboard: staged data pushed on acceptance, popped on done/aborted.
    logic [7:0] sb[$];

    always @(posedge clk) begin
        if (req_valid && req_ready) sb.push_back(din);
    end

    always @(negedge clk) begin
        if (rst && done) begin
            check("sb_nonempty_at_done", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) check("rx_data", 32'(rx_out), 32'(sb.pop_front()));
        end
        if (rst && aborted && sb.size() > 0) sb.delete(0);
    end

    // GAP=3 instance logger.
    int   g_acc[$];
    int   g_dn[$];
    logic g_rdy_hist [0:4095];

    always @(negedge clk) begin
        if (g_req_valid && g_req_ready) g_acc.push_back(cyc);
        if (g_done) g_dn.push_back(cyc);
        if (cyc < 4096) g_rdy_hist[cyc] <= g_req_ready;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(output int c, output bit ok);
        bit hit;
        ok = 1'b0;
        c  = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            hit = req_valid && req_ready;
            @(posedge clk);
            #1;
            if (hit) begin
                ok = 1'b1;
                c  = cyc;
                break;
            end
        end
    endtask

    task automatic wait_done(output int c, output bit ok);
        ok = 1'b0;
        c  = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                c  = cyc;
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
    endtask

    typedef struct {
        logic        req_valid;
        logic        abort;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [18];

    initial begin
        int          c1;
        int          dc;
        bit          ok;
        int          acc[3];
        logic [7:0]  bb[3];
        logic [31:0] rst_vec;
        bit          gap_low;

        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          c1;
        int          dc;
        bit          ok;
        int          acc[3];
        logic [7:0]  bb[3];
        logic [31:0] rst_vec;
        bit          gap_low;

        // Single-frame schedule, WIDTH=8: cycle 0 = acceptance cycle.
        for (int c = 0; c < 18; c++) begin
            tbl[c].req_valid = (c == 0);
            tbl[c].abort     = 1'b0;
            tbl[c].exp       = mk((c == 0) || (c == 17), c == 1, c == 2, c == 14, c == 15,
                                  !((c >= 4) && (c <= 12)), (c >= 1) && (c <= 16), c == 16,
                                  1'b0, ((c >= 4) && (c <= 12)) ? 4'(c - 4) : 4'd0,
                                  (c == 17) ? 16'd1 : 16'd0);
        end
        rst_vec = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
        bb[0] = 8'hA5;
        bb[1] = 8'h3C;
        bb[2] = 8'hFF;

        rst = 1'b0;
        req_valid = 1'b0;
        abort = 1'b0;
        din = 8'h00;
        g_req_valid = 1'b0;
        g_abort = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", vec, rst_vec);
        check("reset_outputs_gap", g_vec, rst_vec);
        step();
        rst = 1'b1;

        // Table-driven single frame, data 0x12
        for (int c = 0; c < 18; c++) begin
            req_valid = tbl[c].req_valid;
            abort     = tbl[c].abort;
            din       = 8'h12;
            @(negedge clk);
            check($sformatf("sched_c%0d", c), vec, tbl[c].exp);
            step();
        end

        // Back-to-back frames with req_valid held high
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din = bb[k];
            wait_accept(acc[k], ok);
            check($sformatf("b2b_accept_%0d", k), 32'(ok), 32'd1);
            if (k == 2) req_valid = 1'b0;
            step();
        end
        check("b2b_spacing_01", 32'(acc[1] - acc[0]), 32'd17);
        check("b2b_spacing_12", 32'(acc[2] - acc[1]), 32'd17);
        wait_done(dc, ok);
        check("b2b_last_done", 32'(ok), 32'd1);
        @(negedge clk);
        check("b2b_frame_cnt", 32'(frame_cnt), 32'd4);
        step();

        // Abort during SHIFT at shift_cnt=4
        req_valid = 1'b1;
        din = 8'h5A;
        wait_accept(c1, ok);
        req_valid = 1'b0;
        check("abort_accept", 32'(ok), 32'd1);
        repeat (7) step();
        abort = 1'b1;
        @(negedge clk);
        check("abort_at_shift_cnt", 32'({mode, shift_cnt}), 32'({1'b0, 4'd4}));
        step();
        abort = 1'b0;
        @(negedge clk);
        check("abort_next_cycle", vec,
              mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 16'd4));
        step();
        @(negedge clk);
        check("aborted_one_cycle", 32'({aborted, busy}), 32'd0);
        step();
        req_valid = 1'b1;
        din = 8'hC3;
        wait_accept(c1, ok);
        req_valid = 1'b0;
        check("post_abort_accept", 32'(ok), 32'd1);
        wait_done(dc, ok);
        check("post_abort_done_cycle", 32'(dc - c1), 32'd15);
        @(negedge clk);
        check("post_abort_frame_cnt", 32'(frame_cnt), 32'd5);
        step();

        // Abort in IDLE blocks acceptance and produces no pulse
        req_valid = 1'b1;
        abort = 1'b1;
        din = 8'h77;
        @(negedge clk);
        check("idle_abort_ready", 32'(req_ready), 32'd0);
        step();
        req_valid = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("idle_abort_no_effect", 32'({busy, aborted}), 32'd0);
        step();

        // Abort in DONE: frame still counts, no aborted pulse
        req_valid = 1'b1;
        din = 8'h81;
        wait_accept(c1, ok);
        req_valid = 1'b0;
        check("done_abort_accept", 32'(ok), 32'd1);
        repeat (15) step();
        abort = 1'b1;
        @(negedge clk);
        check("done_abort_in_done", 32'(done), 32'd1);
        step();
        abort = 1'b0;
        @(negedge clk);
        check("done_abort_after", 32'({aborted, busy, frame_cnt}), 32'({1'b0, 1'b0, 16'd6}));
        step();

        // Reset asserted in cycle 7 of a frame
        req_valid = 1'b1;
        din = 8'h3E;
        wait_accept(c1, ok);
        req_valid = 1'b0;
        check("midrst_accept", 32'(ok), 32'd1);
        repeat (6) step();
        rst = 1'b0;
        #1;
        check("midrst_outputs", vec, rst_vec);
        sb.delete();
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready_after_release", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b1;
        din = 8'h96;
        wait_accept(c1, ok);
        req_valid = 1'b0;
        wait_done(dc, ok);
        check("midrst_done_found", 32'(ok), 32'd1);
        check("midrst_done_cycle16", 32'(dc - c1 + 1), 32'd16);
        @(negedge clk);
        check("midrst_frame_cnt", 32'(frame_cnt), 32'd1);
        step();

        // frame_cnt wrap via preload
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        @(negedge clk);
        check("wrap_preload", 32'(frame_cnt), 32'h0000FFFF);
        step();
        req_valid = 1'b1;
        din = 8'h4B;
        wait_accept(c1, ok);
        req_valid = 1'b0;
        wait_done(dc, ok);
        check("wrap_done", 32'(ok), 32'd1);
        @(negedge clk);
        check("wrap_frame_cnt", 32'(frame_cnt), 32'd0);
        step();

        // GAP=3 instance, req_valid held high
        g_req_valid = 1'b1;
        repeat (45) step();
        g_req_valid = 1'b0;
        repeat (20) step();
        check("gap_accept_count", 32'(g_acc.size()), 32'd3);
        check("gap_done_count", 32'(g_dn.size()), 32'd3);
        if (g_acc.size() >= 2 && g_dn.size() >= 1) begin
            check("gap_spacing", 32'(g_acc[1] - g_acc[0]), 32'd20);
            gap_low = !g_rdy_hist[g_dn[0] + 1] && !g_rdy_hist[g_dn[0] + 2] &&
                      !g_rdy_hist[g_dn[0] + 3];
            check("gap_ready_low_3", 32'(gap_low), 32'd1);
            check("gap_ready_back", 32'(g_rdy_hist[g_dn[0] + 4]), 32'd1);
        end
        check("gap_frame_cnt", 32'(g_frame_cnt), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/txrx_link_ctrl.md
Name: txrx_link_ctrl

Overview:
- Sequencer for the byte-serial TX/RX loop: TX buffer -> parallel-to-serial shifter -> serial-to-parallel shifter -> RX buffer.
- Accepts one frame request per handshake.
- Drives separate TX/RX buffer strobes and the shared shifter mode line through a fixed load/shift/capture schedule.
- Pulses done when the RX buffer output holds the received frame, and keeps a completed-frame count.

Parameters:
- WIDTH, 8, bits per frame; legal range 2..32.
- GAP, 0, idle cycles inserted after each frame before the next request can be accepted; legal range 0..15.
- CW, $clog2(WIDTH+2), width of shift_cnt. Derived; not overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  requester has a frame staged on the TX buffer input.
- req_ready  out  1  controller can accept a request.
- abort  in  1  synchronous cancel of the frame in flight.
- tx_wr  out  1  TX buffer write strobe.
- tx_rd  out  1  TX buffer read strobe.
- rx_wr  out  1  RX buffer write strobe.
- rx_rd  out  1  RX buffer read strobe.
- mode  out  1  shifter mode: 1 = load/capture/hold, 0 = shift.
- shift_cnt  out  CW  shift cycle index.
- busy  out  1  frame in flight or gap running.
- done  out  1  one-cycle pulse: frame delivered.
- aborted  out  1  one-cycle pulse: frame cancelled.
- frame_cnt  out  16  count of completed frames; wraps 0xFFFF -> 0.

Behaviour:
- States and durations:
  - IDLE
  - TX_WR (1 cycle)
  - TX_RD (1)
  - LOAD (1)
  - SHIFT (WIDTH+1)
  - CAPTURE (1)
  - RX_WR (1)
  - RX_RD (1)
  - DONE (1)
  - GAP (GAP cycles; skipped when GAP=0)
  - Then back to IDLE.
- Moore decode from the state register only:
  - tx_wr=1 only in TX_WR.
  - tx_rd=1 only in TX_RD.
  - rx_wr=1 only in RX_WR.
  - rx_rd=1 only in RX_RD.
  - mode=0 only in SHIFT, 1 in every other state.
  - done=1 only in DONE.
  - busy=1 in every state except IDLE.
- req_ready = (state==IDLE) && !abort; forced 0 while rst is low.
- Acceptance is req_valid && req_ready at a rising edge. The next cycle is TX_WR, called cycle 1.
- Schedule relative to acceptance: TX_RD = cycle 2, LOAD = 3, SHIFT = 4..WIDTH+4, CAPTURE = WIDTH+5, RX_WR = WIDTH+6, RX_RD = WIDTH+7, DONE = WIDTH+8. For WIDTH=8, done is high in cycle 16.
- SHIFT lasts WIDTH+1 cycles because the serialiser output is registered, adding one cycle of pipeline.
- shift_cnt counts 0..WIDTH during SHIFT, incrementing each cycle, and is 0 in all other states.
- frame_cnt increments on the edge that leaves DONE.
- With GAP=0, DONE goes to IDLE, so back-to-back frames accept one request every WIDTH+9 cycles.
- Requester must hold the TX buffer input data stable from acceptance through cycle 1.
- abort in any state other than IDLE:
  - next edge -> IDLE, skipping GAP;
  - aborted pulses for one cycle in the following cycle;
  - frame_cnt unchanged; done not asserted.
- abort in IDLE: no effect, no pulse, and blocks acceptance that cycle.
- abort in DONE: the transition to IDLE still happens. The frame counts as completed (frame_cnt increments, done already seen). No aborted pulse.
- req_valid while busy is ignored; no queuing.
- Reset, asserted at any time including mid-frame, immediately forces:
  - state = IDLE;
  - tx_wr = tx_rd = rx_wr = rx_rd = 0;
  - mode = 1; shift_cnt = 0; busy = 0; done = 0; aborted = 0; frame_cnt = 0; req_ready = 0.
- After reset release, req_ready goes high combinationally in IDLE.

Decomposition:
- Shared package txrx_pkg holds:
  - state encoding enum;
  - constants LOAD_CYC=1, CAP_CYC=1;
  - frame-count width FRAME_CNT_W=16.
- One sub-module, txrx_cycle_counter: a loadable down-counter with a zero flag. The FSM reuses it for both SHIFT (load WIDTH) and GAP (load GAP-1).
- shift_cnt is derived from the counter value as WIDTH minus the current count.

Test Plan:
- Reset, single frame with WIDTH=8, GAP=0, req_valid pulsed at cycle 0:
  - tx_wr in cycle 1, tx_rd in 2, mode=0 in cycles 4..12, rx_wr in 14, rx_rd in 15, done in 16;
  - frame_cnt=1; with the datapath attached, RX output = 8'h12 for input 8'h12.
- req_valid held high for 3 frames (0xA5, 0x3C, 0xFF), GAP=0:
  - acceptances spaced exactly 17 cycles apart;
  - three done pulses; frame_cnt=3; outputs match inputs in order.
- GAP=3:
  - req_ready stays low for 3 cycles after done;
  - second acceptance occurs 20 cycles after the first.
- abort during SHIFT (shift_cnt=4):
  - next cycle state=IDLE, mode=1, aborted=1 for one cycle;
  - no done; frame_cnt unchanged;
  - a following request completes normally.
- rst driven low in cycle 7 of a frame:
  - all outputs at reset values within the same cycle, frame_cnt=0;
  - after release a new frame completes with done in cycle 16.
- Wrap: force frame_cnt to 0xFFFF via 65535 frames or a backdoor preload, run one frame -> frame_cnt=0x0000.
